// File: rtl/ir_tx_ctrl.sv
// IR frame sequencer: lead mark/space, N pulse-distance bits, stop mark.
// Define IR_CARRIER_EN to gate the mark envelope with a square-wave carrier.
module ir_tx_ctrl #(
  parameter int N           = 32,
  parameter int TICK_DIV    = 28125,
  parameter int LEAD_MARK   = 16,
  parameter int LEAD_SPACE  = 8,
  parameter int BIT_MARK    = 1,
  parameter int ZERO_SPACE  = 1,
  parameter int ONE_SPACE   = 3,
  parameter int STOP_MARK   = 1,
  parameter int CARRIER_DIV = 658
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_start,
  input  logic i_abort,
  input  logic i_sr_sout,
  output logic o_sr_load,
  output logic o_sr_enable,
  output logic o_busy,
  output logic o_done,
  output logic o_ir
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_LEAD_M, S_LEAD_S,
    S_BIT_M, S_BIT_S, S_STOP_M, S_DONE
  } state_t;

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = $clog2(N + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [15:0]   unit_q, unit_d;
  logic [BW-1:0] bit_cnt_q, bit_cnt_d;
  logic [BW-1:0] bit_nx;
  logic          bit_q, bit_d;
  logic          tick;
  logic          last;
  logic [15:0]   len;
  logic          env;

  always_comb begin
    len = 16'd1;
    unique case (state_q)
      S_LEAD_M: len = 16'(LEAD_MARK);
      S_LEAD_S: len = 16'(LEAD_SPACE);
      S_BIT_M:  len = 16'(BIT_MARK);
      S_BIT_S:  len = bit_q ? 16'(ONE_SPACE) : 16'(ZERO_SPACE);
      S_STOP_M: len = 16'(STOP_MARK);
      default:  len = 16'd1;
    endcase
  end

  assign tick   = (cyc_q == CW'(TICK_DIV - 1));
  assign last   = tick && (unit_q == len - 16'd1);
  assign bit_nx = bit_cnt_q + BW'(1);

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      S_IDLE:   if (i_start) state_d = S_LOAD;
      S_LOAD: begin
        state_d   = S_LEAD_M;
        bit_cnt_d = '0;
      end
      S_LEAD_M: if (last) state_d = S_LEAD_S;
      S_LEAD_S: if (last) state_d = S_BIT_M;
      S_BIT_M: begin
        // sout still holds the pre-shift MSB on this cycle
        if (last) begin
          bit_d   = i_sr_sout;
          state_d = S_BIT_S;
        end
      end
      S_BIT_S: begin
        if (last) begin
          bit_cnt_d = bit_nx;
          state_d   = (bit_nx < BW'(N)) ? S_BIT_M : S_STOP_M;
        end
      end
      S_STOP_M: if (last) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (i_abort) state_d = S_IDLE;
  end

  always_comb begin
    cyc_d  = '0;
    unit_d = '0;
    if (state_q != S_IDLE && state_d == state_q) begin
      if (tick) begin
        unit_d = unit_q + 16'd1;
      end else begin
        cyc_d  = cyc_q + CW'(1);
        unit_d = unit_q;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= S_IDLE;
      cyc_q     <= '0;
      unit_q    <= '0;
      bit_cnt_q <= '0;
      bit_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      unit_q    <= unit_d;
      bit_cnt_q <= bit_cnt_d;
      bit_q     <= bit_d;
    end
  end

  assign o_sr_load   = (state_q == S_LOAD);
  assign o_sr_enable = (state_q == S_LOAD) ||
                       ((state_q == S_BIT_M) && last);
  assign o_busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_done      = (state_q == S_DONE);
  assign env         = (state_q == S_LEAD_M) ||
                       (state_q == S_BIT_M)  ||
                       (state_q == S_STOP_M);

`ifdef IR_CARRIER_EN
  localparam int KW = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  logic [KW-1:0] car_cnt_q, car_cnt_d;
  logic          car_q, car_d;
  logic          mark_d;

  assign mark_d = (state_d == S_LEAD_M) ||
                  (state_d == S_BIT_M)  ||
                  (state_d == S_STOP_M);

  // Restart the carrier high at every mark entry
  always_comb begin
    car_cnt_d = '0;
    car_d     = 1'b0;
    if (mark_d && state_d != state_q) begin
      car_d = 1'b1;
    end else if (mark_d) begin
      if (car_cnt_q == KW'(CARRIER_DIV - 1)) begin
        car_d = ~car_q;
      end else begin
        car_cnt_d = car_cnt_q + KW'(1);
        car_d     = car_q;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      car_cnt_q <= '0;
      car_q     <= 1'b0;
    end else begin
      car_cnt_q <= car_cnt_d;
      car_q     <= car_d;
    end
  end

  assign o_ir = env & car_q;
`else
  assign o_ir = env;
`endif

endmodule

// File: tb/tb_ir_tx_ctrl.sv
// Bench for ir_tx_ctrl: per-cycle scoreboard of the frame envelope,
// table of frames, plus abort, reset and back-to-back sequences.
module tb_ir_tx_ctrl;

  localparam int N  = 4;
  localparam int LM = 4;
  localparam int LS = 2;
  localparam int BM = 1;
  localparam int ZS = 1;
  localparam int OS = 3;
  localparam int SM = 1;
  localparam int CD = 1;
`ifdef IR_CARRIER_EN
  localparam int TD  = 4;
  localparam bit CAR = 1'b1;
`else
  localparam int TD  = 2;
  localparam bit CAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic sout;
  logic sr_load, sr_en, busy, done, ir;
  logic [N-1:0] sr_data = '0;
  logic [N-1:0] sr;

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else if (sr_en) sr <= sr_load ? sr_data : {sr[N-2:0], 1'b0};
  end
  assign sout = sr[N-1];

  ir_tx_ctrl #(
    .N(N), .TICK_DIV(TD), .LEAD_MARK(LM), .LEAD_SPACE(LS),
    .BIT_MARK(BM), .ZERO_SPACE(ZS), .ONE_SPACE(OS),
    .STOP_MARK(SM), .CARRIER_DIV(CD)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start),
    .i_abort(abort), .i_sr_sout(sout), .o_sr_load(sr_load),
    .o_sr_enable(sr_en), .o_busy(busy), .o_done(done), .o_ir(ir)
  );

  // expected vector: {ir, busy, done, load, enable}
  logic [4:0] q[$];
  logic [4:0] last_exp = '0;
  int sb_cmp = 0, sb_fail = 0;
  int n_cmp = 0, n_fail = 0;
  int load_cnt = 0, shift_cnt = 0;

  function automatic int exp_busy(input logic [N-1:0] d);
    int s = 0;
    for (int i = 0; i < N; i++) s += d[i] ? OS : ZS;
    return 1 + TD * (LM + LS + N * BM + s + SM);
  endfunction

  function automatic void push_mark(input int k, input bit en_last);
    for (int c = 0; c < k * TD; c++) begin
      logic b;
      b = CAR ? (((c / CD) % 2) == 0) : 1'b1;
      q.push_back({b, 1'b1, 1'b0, 1'b0, en_last && (c == k * TD - 1)});
    end
  endfunction

  function automatic void push_space(input int k);
    for (int c = 0; c < k * TD; c++) q.push_back(5'b01000);
  endfunction

  function automatic void push_frame(input logic [N-1:0] d);
    q.push_back(5'b01011);
    push_mark(LM, 1'b0);
    push_space(LS);
    for (int i = N - 1; i >= 0; i--) begin
      push_mark(BM, 1'b1);
      push_space(d[i] ? OS : ZS);
    end
    push_mark(SM, 1'b0);
    q.push_back(5'b00100);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) q.delete();
    else if (abort) q.delete();
    else if (start && q.size() == 0 && last_exp != 5'b00100)
      push_frame(sr_data);
  end

  always @(negedge clk) begin : mon
    logic [4:0] e, a;
    if (!rst_n) begin
      last_exp  = '0;
      load_cnt  = 0;
      shift_cnt = 0;
    end else begin
      e = (q.size() != 0) ? q.pop_front() : 5'b00000;
      a = {ir, busy, done, sr_load, sr_en};
      last_exp = e;
      sb_cmp++;
      if (a !== e) begin
        sb_fail++;
        $display("FAIL sb t=%0t got %b required %b", $time, a, e);
      end
      if (sr_en) begin
        if (sr_load) load_cnt++;
        else shift_cnt++;
      end
      if (done) begin
        sb_cmp += 2;
        if (load_cnt != 1) begin
          sb_fail++;
          $display("FAIL load_cnt got %0d required 1", load_cnt);
        end
        if (shift_cnt != N) begin
          sb_fail++;
          $display("FAIL shift_cnt got %0d required %0d", shift_cnt, N);
        end
      end
      if (!busy) begin
        load_cnt  = 0;
        shift_cnt = 0;
      end
    end
  end

  function automatic void chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s got %0d required %0d", nm, act, req);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input bit hold, input bit glitch,
                           output int bcnt, output bit ok);
    bcnt  = 0;
    ok    = 1'b0;
    start = 1'b1;
    for (int c = 0; c < 400; c++) begin
      step();
      if (busy) begin
        bcnt++;
        if (!hold) start = glitch && ((bcnt % 7) == 3);
      end
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!hold) start = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] d;
    bit           glitch;
    int           busy;
  } vec_t;

  vec_t tbl[5];

  initial begin : main
    int  b;
    bit  ok;
    int  sh;
    int  n;
    tbl[0] = '{4'b1010, 1'b0, 0};
    tbl[1] = '{4'b0001, 1'b1, 0};
    tbl[2] = '{4'b0110, 1'b0, 0};
    tbl[3] = '{4'b1000, 1'b0, 0};
    tbl[4] = '{4'b1111, 1'b1, 0};
    for (int i = 0; i < 5; i++) tbl[i].busy = exp_busy(tbl[i].d);

    repeat (3) step();
    chk("reset_outs", int'({ir, busy, done, sr_load, sr_en}), 0);
    rst_n = 1'b1;
    repeat (3) step();
    chk("idle_outs", int'({ir, busy, done, sr_load, sr_en}), 0);

    for (int i = 0; i < 5; i++) begin
      sr_data = tbl[i].d;
      run_frame(1'b0, tbl[i].glitch, b, ok);
      chk("frame_done", int'(ok), 1);
      chk("busy_len", b, tbl[i].busy);
      repeat (3) step();
    end

    // start held through frame 1 and its done cycle
    sr_data = 4'b0000;
    run_frame(1'b1, 1'b0, b, ok);
    chk("b2b1_done", int'(ok), 1);
    chk("b2b1_busy", b, exp_busy(4'b0000));
    sr_data = 4'b1111;
    run_frame(1'b0, 1'b0, b, ok);
    chk("b2b2_done", int'(ok), 1);
    chk("b2b2_busy", b, exp_busy(4'b1111));
    repeat (4) step();

    // abort at the start of the second bit's space
    sr_data = 4'b1010;
    start   = 1'b1;
    sh      = 0;
    ok      = 1'b0;
    for (int c = 0; c < 400; c++) begin
      step();
      if (busy) start = 1'b0;
      if (sr_en && !sr_load) sh++;
      if (sh == 2 && !sr_en && busy) begin
        ok = 1'b1;
        break;
      end
    end
    start = 1'b0;
    chk("abort_reach", int'(ok), 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_outs", int'({ir, busy, done}), 0);
    step();
    chk("abort_nodone", int'(done), 0);
    repeat (2) step();
    sr_data = 4'b1010;
    run_frame(1'b0, 1'b0, b, ok);
    chk("post_abort_done", int'(ok), 1);
    chk("post_abort_busy", b, exp_busy(4'b1010));
    repeat (3) step();

    // asynchronous reset during the lead mark
    sr_data = 4'b0110;
    start   = 1'b1;
    n       = 0;
    for (int c = 0; c < 50 && n < 3; c++) begin
      step();
      if (busy) start = 1'b0;
      if (busy && !sr_load) n++;
    end
    start = 1'b0;
    chk("lead_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", int'({ir, busy, done, sr_load, sr_en}), 0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();
    chk("post_rst_idle", int'({ir, busy, done, sr_load, sr_en}), 0);
    sr_data = 4'b0110;
    run_frame(1'b0, 1'b0, b, ok);
    chk("post_rst_done", int'(ok), 1);
    chk("post_rst_busy", b, exp_busy(4'b0110));
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp + sb_cmp, n_fail + sb_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
